// File: rtl/cache_refill_unit.sv
// cache_refill_unit: L1 miss-refill engine. Issues one burst read per miss,
// assembles the returned beats into a line and writes it into the data array.
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   miss_*                  miss request from the cache controller
//   mem_req_*               burst read request to memory
//   mem_resp_*              returned read beats from memory
//   bank_addr_o, bank_sel_o data-array set/bank for the line write
//   we_way_mask_o, wdata_o  data-array write mask and assembled line
//   refill_done_o, busy_o   completion pulse and activity status
//   err_o                   sticky last-beat protocol error
// Optional: define REFILL_LAST_CHECK_EN to compile in the last-beat checker.
module cache_refill_unit #(
  parameter int NUM_WAYS            = 4,
  parameter int NUM_BANKS           = 4,
  parameter int SETS_PER_BANK_WIDTH = 8,
  parameter int BLOCK_WIDTH         = 512,
  parameter int MEM_DATA_WIDTH      = 64,
  parameter int ADDR_WIDTH          = 32
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           miss_valid_i,
  output logic                           miss_ready_o,
  input  logic [ADDR_WIDTH-1:0]          miss_addr_i,
  input  logic [NUM_WAYS-1:0]            miss_way_i,
  output logic                           mem_req_valid_o,
  input  logic                           mem_req_ready_i,
  output logic [ADDR_WIDTH-1:0]          mem_req_addr_o,
  input  logic                           mem_resp_valid_i,
  output logic                           mem_resp_ready_o,
  input  logic [MEM_DATA_WIDTH-1:0]      mem_resp_data_i,
  input  logic                           mem_resp_last_i,
  output logic [SETS_PER_BANK_WIDTH-1:0] bank_addr_o,
  output logic [$clog2(NUM_BANKS)-1:0]   bank_sel_o,
  output logic [NUM_WAYS-1:0]            we_way_mask_o,
  output logic [BLOCK_WIDTH-1:0]         wdata_o,
  output logic                           refill_done_o,
  output logic                           busy_o,
  output logic                           err_o
);

  localparam int BEATS = BLOCK_WIDTH / MEM_DATA_WIDTH;
  localparam int OFF   = $clog2(BLOCK_WIDTH / 8);
  localparam int BSW   = $clog2(NUM_BANKS);
  localparam int CW    = $clog2(BEATS) + 1;
  localparam int MW    = MEM_DATA_WIDTH;
  localparam logic [CW-1:0] LAST_IDX = CW'(BEATS - 1);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RECV,
    WRITE
  } state_t;

  state_t state, state_nxt;

  logic [ADDR_WIDTH-1:0]          line_addr_q;
  logic [NUM_WAYS-1:0]            way_q;
  logic [BSW-1:0]                 bank_sel_q;
  logic [SETS_PER_BANK_WIDTH-1:0] bank_addr_q;
  logic [CW-1:0]                  beat_cnt;
  logic [BLOCK_WIDTH-1:0]         line_buf;

  logic miss_fire;
  logic beat_fire;
  logic last_beat;

  // Line offset bits never matter: the line is always fetched whole.
  logic [OFF-1:0] unused_offset;
  assign unused_offset = miss_addr_i[OFF-1:0];

  assign miss_fire = (state == IDLE) & miss_valid_i & ~rst_i;
  assign beat_fire = (state == RECV) & mem_resp_valid_i & ~rst_i;
  assign last_beat = (beat_cnt == LAST_IDX);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Outputs are decoded from state only; rst_i gating keeps them
  // quiet while reset is held, including before the first edge.
  always_comb begin
    state_nxt        = state;
    miss_ready_o     = 1'b0;
    mem_req_valid_o  = 1'b0;
    mem_resp_ready_o = 1'b0;
    we_way_mask_o    = '0;
    refill_done_o    = 1'b0;
    busy_o           = (state != IDLE) & ~rst_i;
    unique case (state)
      IDLE: begin
        miss_ready_o = ~rst_i;
        if (miss_valid_i) begin
          state_nxt = REQ;
        end
      end
      REQ: begin
        mem_req_valid_o = ~rst_i;
        if (mem_req_ready_i) begin
          state_nxt = RECV;
        end
      end
      RECV: begin
        mem_resp_ready_o = ~rst_i;
        if (mem_resp_valid_i && last_beat) begin
          state_nxt = WRITE;
        end
      end
      WRITE: begin
        we_way_mask_o = rst_i ? '0 : way_q;
        refill_done_o = ~rst_i;
        state_nxt     = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      line_addr_q <= '0;
      way_q       <= '0;
      bank_sel_q  <= '0;
      bank_addr_q <= '0;
      beat_cnt    <= '0;
      line_buf    <= '0;
    end else begin
      if (miss_fire) begin
        line_addr_q <= {miss_addr_i[ADDR_WIDTH-1:OFF], {OFF{1'b0}}};
        way_q       <= miss_way_i;
        bank_sel_q  <= miss_addr_i[OFF +: BSW];
        bank_addr_q <= miss_addr_i[OFF+BSW +: SETS_PER_BANK_WIDTH];
      end
      if (state == REQ && mem_req_ready_i) begin
        beat_cnt <= '0;
      end
      if (beat_fire) begin
        for (int b = 0; b < BEATS; b++) begin
          if (beat_cnt == CW'(b)) begin
            line_buf[b*MW +: MW] <= mem_resp_data_i;
          end
        end
        beat_cnt <= beat_cnt + 1'b1;
      end
    end
  end

  assign mem_req_addr_o = line_addr_q;
  assign bank_addr_o    = bank_addr_q;
  assign bank_sel_o     = bank_sel_q;
  assign wdata_o        = line_buf;

`ifdef REFILL_LAST_CHECK_EN
  // last must mark exactly the final beat of the burst.
  logic err_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_q <= 1'b0;
    end else if (beat_fire && (mem_resp_last_i != last_beat)) begin
      err_q <= 1'b1;
    end
  end

  assign err_o = err_q;
`else
  logic unused_last;
  assign unused_last = mem_resp_last_i;
  assign err_o       = 1'b0;
`endif

endmodule

// File: doc/cache_refill_unit.md
# cache_refill_unit

Miss-refill engine for the L1 cache, sitting directly upstream of the per-way/per-bank data SRAM array. It accepts a block-aligned miss from the cache controller, issues one burst read to memory, and assembles the returned beats into a full line. It then performs a single-cycle line write into the selected way/bank of the data array and pulses completion back to the controller.

## Interface
Parameters:
- NUM_WAYS, 4, associativity; width of the way mask
- NUM_BANKS, 4, data-array banks; power of 2
- SETS_PER_BANK_WIDTH, 8, log2 of sets per bank
- BLOCK_WIDTH, 512, line width in bits
- MEM_DATA_WIDTH, 64, memory beat width; BLOCK_WIDTH must be a multiple of it
- ADDR_WIDTH, 32, physical address width

Derived values:
- BEATS = BLOCK_WIDTH/MEM_DATA_WIDTH
- OFF = log2(BLOCK_WIDTH/8)
- BSW = log2(NUM_BANKS)

Ports (one clock; reset is synchronous and active-high):
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- miss_valid_i  in  1  refill request
- miss_ready_o  out  1  high only in IDLE
- miss_addr_i  in  ADDR_WIDTH  miss address; low OFF bits ignored
- miss_way_i  in  NUM_WAYS  one-hot victim way
- mem_req_valid_o  out  1  burst read request
- mem_req_ready_i  in  1  memory accepts request
- mem_req_addr_o  out  ADDR_WIDTH  line-aligned address (low OFF bits zero)
- mem_resp_valid_i  in  1  read beat valid
- mem_resp_ready_o  out  1  high only in RECV
- mem_resp_data_i  in  MEM_DATA_WIDTH  beat data
- mem_resp_last_i  in  1  final beat marker
- bank_addr_o  out  SETS_PER_BANK_WIDTH  data-array bank address
- bank_sel_o  out  BSW  data-array bank select
- we_way_mask_o  out  NUM_WAYS  data-array write mask; zero except in WRITE
- wdata_o  out  BLOCK_WIDTH  assembled line
- refill_done_o  out  1  one-cycle completion pulse
- busy_o  out  1  state != IDLE
- err_o  out  1  sticky protocol error (see Configuration)

## Operation
States and transitions:
- IDLE: on miss_valid_i & miss_ready_o, latch the miss; go to REQ.
  - Latched fields: line address = miss_addr_i with low OFF bits cleared; way mask = miss_way_i; bank_sel = addr[OFF +: BSW]; bank_addr = addr[OFF+BSW +: SETS_PER_BANK_WIDTH].
- REQ: mem_req_valid_o=1 with the latched line address. On mem_req_ready_i, go to RECV with beat_cnt=0. Valid/address are held stable until the handshake.
- RECV: mem_resp_ready_o=1. Each accepted beat writes line_buf[beat_cnt*MEM_DATA_WIDTH +: MEM_DATA_WIDTH] (beat 0 in the LSBs), then beat_cnt increments. beat_cnt is $clog2(BEATS)+1 bits wide and never wraps. Accepting beat BEATS-1 moves to WRITE.
- WRITE: one cycle.
  - we_way_mask_o = latched way; bank_addr_o/bank_sel_o = latched values; wdata_o = line_buf.
  - refill_done_o=1 in this same cycle.
  - Next state is IDLE.

Rules:
- Outside WRITE, we_way_mask_o=0 and refill_done_o=0. bank_addr_o, bank_sel_o and wdata_o always reflect the latched/buffered values.
- An all-zero miss_way_i produces no array write. The refill still completes and refill_done_o still pulses.
- Beat count alone terminates RECV. mem_resp_last_i is used only by the optional checker.
- Beats presented outside RECV are not accepted (mem_resp_ready_o=0).

## Timing
- Reset (rst_i high at a clock edge):
  - state=IDLE; beat_cnt=0; line_buf=0; latched address/way/bank=0; err_o=0.
  - All valid, ready, done and mask outputs are 0 while rst_i is high.
  - miss_ready_o=1 from the first cycle with rst_i low.
- Reset mid-operation aborts the refill at that edge: no array write, no done pulse, partial line discarded.
- Miss handshake at cycle 0:
  - mem_req_valid_o first high at cycle 1.
  - With zero memory stalls: request accepted at cycle 1, beats at cycles 2..BEATS+1, WRITE at cycle BEATS+2, miss_ready_o high again at cycle BEATS+3.
  - Minimum miss-to-miss period is BEATS+3 cycles.
- Gaps in mem_resp_valid_i stall RECV with no state loss.
- Controller outputs (miss_ready_o, busy_o, refill_done_o) are registered-state decodes with no combinational path from miss_valid_i.

## Configuration
- REFILL_LAST_CHECK_EN defined: protocol checker is compiled in. err_o sets (sticky until reset) if either:
  - mem_resp_last_i=1 on an accepted beat other than beat BEATS-1, or
  - mem_resp_last_i=0 on accepted beat BEATS-1.
  - Refill behaviour is unchanged; the line is still written.
- Not defined: err_o is tied 0 and mem_resp_last_i is unused.

## Test plan
- Defaults; miss addr 0x0000_1A40, way 4'b0100; 8 beats 0x11..0x88 with no stalls -> request addr 0x0000_1A40; WRITE at cycle 10 with bank_sel=1, bank_addr=0x1A, mask 4'b0100, wdata[63:0]=0x11, wdata[511:448]=0x88; done pulse exactly 1 cycle.
- mem_req_ready_i held low 5 cycles, plus random 0-3 cycle gaps between beats -> mem_req_valid_o/mem_req_addr_o stable throughout; line assembled correctly; exactly one write.
- rst_i asserted after beat 4 -> no write, no done; busy_o=0 next cycle; a new miss then refills fully with no stale data.
- miss_way_i=0 -> we_way_mask_o stays 0 throughout; refill_done_o still pulses.
- With REFILL_LAST_CHECK_EN: last asserted on beat 3 -> err_o=1 and sticky; line still written. Without the macro -> err_o stays 0.
- Back-to-back misses with miss_valid_i held high -> second handshake occurs on the cycle after WRITE; miss_ready_o=0 for the whole busy interval.
